axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

AXI4 slave responder backed by an internal word-addressed RAM. It accepts the INCR bursts issued by the stream-to-AXI adapter on the AW/W/B and AR/R channels. Used as the on-chip target for the adapter in simulation and in small-memory builds. One burst is serviced at a time, and the two directions are arbitrated round-robin.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits (power of two, ≥ 8)
- ADDR_WIDTH, 32, byte address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width
- ID_WIDTH, 8, AXI ID width
- MEM_WORDS, 1024, RAM depth in DATA_WIDTH words (power of two)

Ports:
- aclk  in  1  clock; the block has one clock and everything is on its rising edge
- reset  in  1  synchronous, active-high reset
- s_awid/s_arid  in  ID_WIDTH  request ID
- s_awaddr/s_araddr  in  ADDR_WIDTH  byte start address
- s_awlen/s_arlen  in  8  beats minus one
- s_awsize/s_arsize, s_awburst/s_arburst  in  3/2  accepted and ignored; every transfer is full-width INCR
- s_awvalid/s_arvalid  in  1; s_awready/s_arready  out  1
- s_wdata  in  DATA_WIDTH; s_wstrb  in  STRB_WIDTH; s_wlast  in  1; s_wvalid  in  1; s_wready  out  1
- s_bid  out  ID_WIDTH; s_bresp  out  2; s_bvalid  out  1; s_bready  in  1
- s_rid  out  ID_WIDTH; s_rdata  out  DATA_WIDTH; s_rresp  out  2; s_rlast  out  1; s_rvalid  out  1; s_rready  in  1

## Operation
- FSM states: IDLE, WRITE, WRESP, READ.
- **IDLE.** s_awready and s_arready may be high only in IDLE.
  - Both valid in the same cycle: grant the direction not served last. After reset, write wins.
  - The losing ready is held low combinationally so that only one request is accepted.
- **Request capture.** On acceptance, latch the ID, the beat count (len+1), and word index = addr >> log2(STRB_WIDTH).
  - Low address bits are ignored.
  - The word index increments by 1 per beat.
  - The index wraps modulo MEM_WORDS. This is overridden in the out-of-range case under Configuration.
- **WRITE.**
  - s_wready is high.
  - Each W handshake writes the bytes enabled by s_wstrb to RAM[index].
  - The internal beat counter, not s_wlast, ends the burst. A mismatched s_wlast is ignored.
  - After the final beat, go to WRESP.
- **WRESP.**
  - s_bvalid is high, with s_bid = latched ID and s_bresp = 2'b00.
  - Return to IDLE on s_bready.
- **READ.**
  - RAM read latency is 1 clk. A 2-entry output buffer lets R sustain 1 beat/clk.
  - s_rlast is high on beat len.
  - s_rresp is 2'b00.
  - Return to IDLE on the handshake of the last beat.
- RAM contents are not reset and are kept across reset.

## Timing
- Reset values: s_awready=0, s_arready=0, s_wready=0, s_bvalid=0, s_rvalid=0, s_rlast=0, s_bresp=0, s_rresp=0. State = IDLE and round-robin priority = write.
- Ready outputs go high the cycle after reset deasserts.
- **Write.**
  - AW handshake at cycle T → s_wready=1 from T+1.
  - Last W handshake at cycle W → s_bvalid=1 at W+1.
  - Next AW/AR can be accepted the cycle after the B handshake.
- **Read.**
  - AR handshake at T → first s_rvalid at T+2.
  - With s_rready held high, one beat per clk follows.
  - With s_rready low, s_rdata/s_rlast/s_rid hold stable and no beat is dropped or duplicated.
  - Next request can be accepted the cycle after the last R handshake.
- A VALID, once asserted, stays high until its handshake.
- Reset mid-burst: all valid/ready outputs drop the next cycle, the burst is abandoned, and no B response is issued.
- Write and read to the same word in consecutive bursts: the read returns the newly written data.

## Configuration
- AXI_MEM_RESPONDER_RANGE_CHECK_EN
  - **Defined:** a burst whose start word + len ≥ MEM_WORDS is marked out-of-range at acceptance.
    - Writes: all data beats are accepted but not stored, and s_bresp = 2'b10 (SLVERR).
    - Reads: s_rdata = 0 and s_rresp = 2'b10 on every beat.
    - Beat count and timing are unchanged.
  - **Undefined:** no check. The index wraps modulo MEM_WORDS and responses are always OKAY.

## Test plan
- **Reset state.** Reset for 3 clks with random inputs → all outputs at reset values. One clk after release, s_awready=s_arready=1.
- **Write then read back.** AW addr 0x40, len 15, data 0..15 with full strobes → B OKAY with the ID echoed. Then AR 0x40 len 15 with rready=1 → 16 beats, data 0..15, first at T+2, rlast only on beat 15.
- **Byte strobes and backpressure.** Write 0xAABBCCDD to 0x0, then 0x11223344 with strobe 4'b0101 → read-back 0xAA22CC44.
  - Toggle rready 1010… during a 4-beat read → no loss or duplication, and data stays stable while stalled.
- **Simultaneous requests.** AW and AR valid in the same cycle, twice in a row → write served first, then read. Priority alternates afterwards.
- **Range limit.** MEM_WORDS=1024, write word 1020 with len 7.
  - With the macro: SLVERR, and RAM[1020..1023] and RAM[0..3] unchanged.
  - Without it: OKAY, and words 1020..1023 and 0..3 are written.
- **Reset mid-burst.** Reset asserted after write beat 5 of 16 → no B response. After release, a new AR to the same address returns beats 0..4 new and 5..15 old.

Source files
------------

// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst slave over an internal word RAM; define AXI_MEM_RESPONDER_RANGE_CHECK_EN to SLVERR bursts running past the top.
// Latency: W ready the cycle after AW, B the cycle after the last W beat, first R beat two cycles after AR.
// Backpressure: one burst at a time, directions round-robin; a 2-entry R buffer pauses RAM reads while s_rready is low.
module axi_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_WIDTH-1:0]   s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);
    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

    state_t                state_q, state_d;
    logic                  prio_rd_q, prio_rd_d;
    logic                  ready_en_q, ready_en_d;
    logic                  oor_q, oor_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic [8:0]            iss_q, iss_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rbuf_q [2];
    logic [1:0]            rlast_buf_q;

    logic [ADDR_WIDTH-1:0] aw_word, ar_word;
    logic                  rd_issue, rd_more, r_hs, mem_we;

    assign aw_word = s_awaddr >> SHIFT;
    assign ar_word = s_araddr >> SHIFT;

`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] MEM_TOP = (ADDR_WIDTH + 1)'(MEM_WORDS);

    function automatic logic past_top(input logic [ADDR_WIDTH-1:0] word, input logic [7:0] len);
        logic [ADDR_WIDTH:0] end_word;
        end_word = {1'b0, word} + {{(ADDR_WIDTH - 7){1'b0}}, len};
        return end_word >= MEM_TOP;
    endfunction
`endif

    assign rd_more = (iss_q != ({1'b0, len_q} + 9'd1));
    assign s_rvalid = (state_q == READ) && (cnt_q != 2'd0);
    assign r_hs     = s_rvalid && s_rready;
    assign mem_we   = (state_q == WRITE) && s_wvalid && !oor_q;

    always_comb begin
        state_d    = state_q;
        prio_rd_d  = prio_rd_q;
        ready_en_d = 1'b1;
        oor_d      = oor_q;
        id_d       = id_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        iss_d      = iss_q;
        idx_d      = idx_q;
        s_awready  = 1'b0;
        s_arready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        rd_issue   = 1'b0;
        case (state_q)
            IDLE: begin
                // The losing direction's ready is masked so only one request lands.
                s_awready = ready_en_q && !(s_arvalid && prio_rd_q);
                s_arready = ready_en_q && !(s_awvalid && !prio_rd_q);
                if (s_awvalid && s_awready) begin
                    state_d   = WRITE;
                    prio_rd_d = 1'b1;
                    id_d      = s_awid;
                    len_d     = s_awlen;
                    wcnt_d    = 8'd0;
                    idx_d     = aw_word[IDX_W-1:0];
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
                    oor_d     = past_top(aw_word, s_awlen);
`else
                    oor_d     = 1'b0;
`endif
                end else if (s_arvalid && s_arready) begin
                    state_d   = READ;
                    prio_rd_d = 1'b0;
                    id_d      = s_arid;
                    len_d     = s_arlen;
                    iss_d     = 9'd0;
                    idx_d     = ar_word[IDX_W-1:0];
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
                    oor_d     = past_top(ar_word, s_arlen);
`else
                    oor_d     = 1'b0;
`endif
                end
            end
            WRITE: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (wcnt_q == len_q) begin
                        state_d = WRESP;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
            end
            WRESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                // A read in flight always has a slot: issue only if one is free or being freed now.
                rd_issue = rd_more && ((cnt_q != 2'd2) || r_hs);
                if (rd_issue) begin
                    iss_d = iss_q + 9'd1;
                    idx_d = idx_q + IDX_W'(1);
                end
                if (r_hs && s_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + {1'b0, rd_issue} - {1'b0, r_hs};
        wptr_d = wptr_q ^ rd_issue;
        rptr_d = rptr_q ^ r_hs;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= IDLE;
            prio_rd_q  <= 1'b0;
            ready_en_q <= 1'b0;
            oor_q      <= 1'b0;
            cnt_q      <= 2'd0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_rd_q  <= prio_rd_d;
            ready_en_q <= ready_en_d;
            oor_q      <= oor_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        id_q   <= id_d;
        len_q  <= len_d;
        wcnt_q <= wcnt_d;
        iss_q  <= iss_d;
        idx_q  <= idx_d;
    end

    // RAM is deliberately left out of reset so contents survive it.
    always_ff @(posedge aclk) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (mem_we && s_wstrb[b]) begin
                mem[idx_q][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
        if (rd_issue) begin
            rbuf_q[wptr_q]      <= oor_q ? '0 : mem[idx_q];
            rlast_buf_q[wptr_q] <= (iss_q == {1'b0, len_q});
        end
    end

    assign s_bid   = id_q;
    assign s_bresp = oor_q ? 2'b10 : 2'b00;
    assign s_rid   = id_q;
    assign s_rdata = rbuf_q[rptr_q];
    assign s_rlast = s_rvalid && rlast_buf_q[rptr_q];
    assign s_rresp = oor_q ? 2'b10 : 2'b00;

    logic unused_inputs;
    assign unused_inputs = ^{s_awsize, s_arsize, s_awburst, s_arburst, s_wlast, aw_word, ar_word};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: reset, burst write/read, strobes, R backpressure,
// arbitration, range wrap/limit and reset in the middle of a write burst.
module tb_axi_mem_responder;
    logic        aclk = 1'b0;
    logic        reset;
    logic [7:0]  s_awid, s_arid;
    logic [31:0] s_awaddr, s_araddr;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst;
    logic        s_awvalid, s_awready, s_arvalid, s_arready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic [7:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic [7:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast, s_rvalid, s_rready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] wr_data [16];
    logic [31:0] rd_data [16];
    logic        rd_last [16];
    logic [7:0]  rd_id   [16];
    logic [1:0]  rd_resp [16];
    int          rd_cyc  [16];
    int          rd_n;

    axi_mem_responder dut (
        .aclk(aclk), .reset(reset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s_awid = 8'h0; s_awaddr = 32'h0; s_awlen = 8'h0; s_awsize = 3'd2; s_awburst = 2'b01; s_awvalid = 1'b0;
        s_arid = 8'h0; s_araddr = 32'h0; s_arlen = 8'h0; s_arsize = 3'd2; s_arburst = 2'b01; s_arvalid = 1'b0;
        s_wdata = 32'h0; s_wstrb = 4'h0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
    endtask

    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len, output int hs);
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 64 && hs < 0; i++) begin
            #1;
            if (s_awready) hs = cyc;
            tick();
        end
        s_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len, output int hs);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 64 && hs < 0; i++) begin
            #1;
            if (s_arready) hs = cyc;
            tick();
        end
        s_arvalid = 1'b0;
    endtask

    task automatic send_w(input int n, input int last_idx, input logic [3:0] strb, output int last_hs, output bit ok);
        ok = 1'b1;
        last_hs = -1;
        for (int b = 0; b < n; b++) begin
            int hs;
            hs = -1;
            s_wdata = wr_data[b]; s_wstrb = strb; s_wlast = (b == last_idx); s_wvalid = 1'b1;
            for (int i = 0; i < 64 && hs < 0; i++) begin
                #1;
                if (s_wready) hs = cyc;
                tick();
            end
            if (hs < 0) ok = 1'b0;
            last_hs = hs;
        end
        s_wvalid = 1'b0;
        s_wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [7:0] id, output logic [1:0] resp, output int seen, output bit ok);
        s_bready = 1'b1;
        seen = -1;
        id = 8'hxx;
        resp = 2'bxx;
        for (int i = 0; i < 64 && seen < 0; i++) begin
            #1;
            if (s_bvalid) begin
                seen = cyc; id = s_bid; resp = s_bresp;
            end
            tick();
        end
        ok = (seen >= 0);
    endtask

    task automatic rd_collect(input int n, output bit ok);
        s_rready = 1'b1;
        rd_n = 0;
        for (int i = 0; i < 200 && rd_n < n; i++) begin
            #1;
            if (s_rvalid && s_rready) begin
                rd_data[rd_n] = s_rdata; rd_last[rd_n] = s_rlast; rd_id[rd_n] = s_rid;
                rd_resp[rd_n] = s_rresp; rd_cyc[rd_n] = cyc;
                rd_n++;
            end
            tick();
        end
        ok = (rd_n == n);
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_awid = 8'($urandom); s_awaddr = $urandom; s_awlen = 8'($urandom); s_awvalid = 1'($urandom);
            s_arid = 8'($urandom); s_araddr = $urandom; s_arlen = 8'($urandom); s_arvalid = 1'($urandom);
            s_wdata = $urandom; s_wstrb = 4'($urandom); s_wlast = 1'($urandom); s_wvalid = 1'($urandom);
            s_bready = 1'($urandom); s_rready = 1'($urandom);
            tick();
            outs = {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast, s_bresp, s_rresp};
            total++;
            if (outs !== 10'b0) begin bad++; $display("FAIL reset_outputs[%0d]: got %b want %b", k, outs, 10'b0); end
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        total++;
        if ({s_awready, s_arready} !== 2'b00) begin bad++; $display("FAIL ready_before_release_edge: got %b want 00", {s_awready, s_arready}); end
        tick();
        total++;
        if ({s_awready, s_arready} !== 2'b11) begin bad++; $display("FAIL ready_after_release: got %b want 11", {s_awready, s_arready}); end
    endtask

    task automatic test_write_read();
        int t, wl, bc;
        bit ok;
        logic [7:0] bid;
        logic [1:0] bresp;
        for (int i = 0; i < 16; i++) wr_data[i] = 32'(i);
        send_aw(8'h5A, 32'h40, 8'd15, t);
        total++;
        if (t < 0) begin bad++; $display("FAIL wr_aw_accept: got timeout want handshake"); end
        total++;
        if (s_wready !== 1'b1) begin bad++; $display("FAIL wready_after_aw: got %b want 1", s_wready); end
        send_w(16, 15, 4'hF, wl, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL wr_w_beats: got timeout want 16 beats"); end
        wait_b(bid, bresp, bc, ok);
        total++;
        if (bc !== wl + 1) begin bad++; $display("FAIL b_timing: got cycle %0d want %0d", bc, wl + 1); end
        total++;
        if ({bid, bresp} !== {8'h5A, 2'b00}) begin bad++; $display("FAIL b_id_resp: got %h/%b want 5a/00", bid, bresp); end
        send_ar(8'h33, 32'h40, 8'd15, t);
        rd_collect(16, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rd_beats: got %0d want 16", rd_n); end
        total++;
        if (rd_cyc[0] !== t + 2) begin bad++; $display("FAIL r_first_timing: got cycle %0d want %0d", rd_cyc[0], t + 2); end
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({rd_data[i], rd_last[i], rd_id[i], rd_resp[i]} !== {32'(i), (i == 15), 8'h33, 2'b00}) begin
                bad++;
                $display("FAIL r_beat[%0d]: got data=%h last=%b id=%h resp=%b want data=%h last=%b id=33 resp=00",
                         i, rd_data[i], rd_last[i], rd_id[i], rd_resp[i], 32'(i), (i == 15));
            end
            total++;
            if (rd_cyc[i] !== t + 2 + i) begin bad++; $display("FAIL r_beat_rate[%0d]: got cycle %0d want %0d", i, rd_cyc[i], t + 2 + i); end
        end
    endtask

    task automatic test_strobe_backpressure();
        int t, wl, bc, n;
        bit ok, stalled;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [31:0] held_d;
        logic held_l;
        wr_data[0] = 32'hAABBCCDD;
        send_aw(8'h01, 32'h0, 8'd0, t);
        send_w(1, 0, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        wr_data[0] = 32'h11223344;
        send_aw(8'h02, 32'h0, 8'd0, t);
        send_w(1, 0, 4'b0101, wl, ok);
        wait_b(bid, bresp, bc, ok);
        total++;
        if ({bid, bresp} !== {8'h02, 2'b00}) begin bad++; $display("FAIL strb_b: got %h/%b want 02/00", bid, bresp); end
        send_ar(8'h03, 32'h0, 8'd0, t);
        rd_collect(1, ok);
        total++;
        if ({rd_data[0], rd_last[0]} !== {32'hAA22CC44, 1'b1}) begin
            bad++; $display("FAIL strb_readback: got %h last=%b want aa22cc44 last=1", rd_data[0], rd_last[0]);
        end
        send_ar(8'h04, 32'h40, 8'd3, t);
        n = 0;
        stalled = 1'b0;
        held_d = 32'h0;
        held_l = 1'b0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            s_rready = (k % 2 == 0);
            #1;
            if (stalled) begin
                total++;
                if ({s_rvalid, s_rdata, s_rlast} !== {1'b1, held_d, held_l}) begin
                    bad++; $display("FAIL r_stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", s_rvalid, s_rdata, s_rlast, held_d, held_l);
                end
                stalled = 1'b0;
            end
            if (s_rvalid && s_rready) begin
                total++;
                if ({s_rdata, s_rlast} !== {32'(n), (n == 3)}) begin
                    bad++; $display("FAIL r_toggle_beat[%0d]: got d=%h l=%b want d=%h l=%b", n, s_rdata, s_rlast, 32'(n), (n == 3));
                end
                n++;
            end else if (s_rvalid) begin
                stalled = 1'b1; held_d = s_rdata; held_l = s_rlast;
            end
            tick();
        end
        s_rready = 1'b1;
        total++;
        if (n !== 4) begin bad++; $display("FAIL r_toggle_count: got %0d want 4", n); end
        #1;
        total++;
        if (s_rvalid !== 1'b0) begin bad++; $display("FAIL r_no_extra_beat: got rvalid=%b want 0", s_rvalid); end
    endtask

    task automatic test_simultaneous();
        int t, wl, bc;
        bit ok;
        logic [7:0] bid;
        logic [1:0] bresp;
        wr_data[0] = 32'hC0DE0001;
        s_awid = 8'h11; s_awaddr = 32'h300; s_awlen = 8'd0; s_awvalid = 1'b1;
        s_arid = 8'h22; s_araddr = 32'h300; s_arlen = 8'd0; s_arvalid = 1'b1;
        #1;
        total++;
        if ({s_awready, s_arready} !== 2'b10) begin bad++; $display("FAIL grant1_write: got %b want 10", {s_awready, s_arready}); end
        tick();
        s_awid = 8'h12; s_awaddr = 32'h304;
        send_w(1, 0, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        total++;
        if ({bid, bresp} !== {8'h11, 2'b00}) begin bad++; $display("FAIL grant1_b: got %h/%b want 11/00", bid, bresp); end
        s_awvalid = 1'b1;
        #1;
        total++;
        if ({s_awready, s_arready} !== 2'b01) begin bad++; $display("FAIL grant2_read: got %b want 01", {s_awready, s_arready}); end
        tick();
        s_arvalid = 1'b0;
        rd_collect(1, ok);
        total++;
        if ({rd_data[0], rd_id[0]} !== {32'hC0DE0001, 8'h22}) begin
            bad++; $display("FAIL grant2_data: got %h id=%h want c0de0001 id=22", rd_data[0], rd_id[0]);
        end
        s_arid = 8'h23; s_araddr = 32'h304; s_arlen = 8'd0; s_arvalid = 1'b1;
        #1;
        total++;
        if ({s_awready, s_arready} !== 2'b10) begin bad++; $display("FAIL grant3_write: got %b want 10", {s_awready, s_arready}); end
        tick();
        s_awvalid = 1'b0;
        wr_data[0] = 32'hC0DE0002;
        send_w(1, 0, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        total++;
        if ({bid, bresp} !== {8'h12, 2'b00}) begin bad++; $display("FAIL grant3_b: got %h/%b want 12/00", bid, bresp); end
        send_ar(8'h23, 32'h304, 8'd0, t);
        rd_collect(1, ok);
        total++;
        if ({rd_data[0], rd_id[0]} !== {32'hC0DE0002, 8'h23}) begin
            bad++; $display("FAIL grant4_data: got %h id=%h want c0de0002 id=23", rd_data[0], rd_id[0]);
        end
    endtask

    task automatic test_range();
        int t, wl, bc;
        bit ok;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [31:0] exp_hi, exp_lo;
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hE0 + 32'(i);
        send_aw(8'h70, 32'hFF0, 8'd3, t);
        send_w(4, 3, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'hF0 + 32'(i);
        send_aw(8'h71, 32'h0, 8'd3, t);
        send_w(4, 3, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        for (int i = 0; i < 8; i++) wr_data[i] = 32'h100 + 32'(i);
        send_aw(8'h77, 32'hFF0, 8'd7, t);
        send_w(8, 7, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
        total++;
        if ({bid, bresp} !== {8'h77, 2'b10}) begin bad++; $display("FAIL range_b: got %h/%b want 77/10", bid, bresp); end
`else
        total++;
        if ({bid, bresp} !== {8'h77, 2'b00}) begin bad++; $display("FAIL range_b: got %h/%b want 77/00", bid, bresp); end
`endif
        send_ar(8'h78, 32'hFF0, 8'd3, t);
        rd_collect(4, ok);
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
            exp_hi = 32'hE0 + 32'(i);
`else
            exp_hi = 32'h100 + 32'(i);
`endif
            total++;
            if ({rd_data[i], rd_resp[i]} !== {exp_hi, 2'b00}) begin
                bad++; $display("FAIL range_top[%0d]: got %h/%b want %h/00", i, rd_data[i], rd_resp[i], exp_hi);
            end
        end
        send_ar(8'h79, 32'h0, 8'd3, t);
        rd_collect(4, ok);
        for (int i = 0; i < 4; i++) begin
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
            exp_lo = 32'hF0 + 32'(i);
`else
            exp_lo = 32'h104 + 32'(i);
`endif
            total++;
            if ({rd_data[i], rd_resp[i]} !== {exp_lo, 2'b00}) begin
                bad++; $display("FAIL range_wrap[%0d]: got %h/%b want %h/00", i, rd_data[i], rd_resp[i], exp_lo);
            end
        end
`ifdef AXI_MEM_RESPONDER_RANGE_CHECK_EN
        send_ar(8'h7A, 32'hFF0, 8'd7, t);
        rd_collect(8, ok);
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {32'h0, 2'b10, (i == 7)}) begin
                bad++; $display("FAIL range_rd_err[%0d]: got %h/%b/%b want 0/10/%b", i, rd_data[i], rd_resp[i], rd_last[i], (i == 7));
            end
        end
`endif
    endtask

    task automatic test_reset_midburst();
        int t, wl, bc;
        bit ok, seen_b;
        logic [7:0] bid;
        logic [1:0] bresp;
        logic [31:0] exp_d;
        for (int i = 0; i < 16; i++) wr_data[i] = 32'hA00 + 32'(i);
        send_aw(8'h50, 32'h200, 8'd15, t);
        send_w(16, 15, 4'hF, wl, ok);
        wait_b(bid, bresp, bc, ok);
        for (int i = 0; i < 16; i++) wr_data[i] = 32'hB00 + 32'(i);
        send_aw(8'h55, 32'h200, 8'd15, t);
        send_w(5, 15, 4'hF, wl, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midburst_w_beats: got timeout want 5 beats"); end
        reset = 1'b1;
        tick();
        total++;
        if ({s_wready, s_bvalid, s_awready, s_arready, s_rvalid} !== 5'b0) begin
            bad++; $display("FAIL midburst_reset_outputs: got %b want 00000", {s_wready, s_bvalid, s_awready, s_arready, s_rvalid});
        end
        tick();
        reset = 1'b0;
        seen_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (s_bvalid) seen_b = 1'b1;
            tick();
        end
        total++;
        if (seen_b !== 1'b0) begin bad++; $display("FAIL midburst_no_b: got bvalid seen=%b want 0", seen_b); end
        send_ar(8'h56, 32'h200, 8'd15, t);
        rd_collect(16, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midburst_rd_beats: got %0d want 16", rd_n); end
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 5) ? (32'hB00 + 32'(i)) : (32'hA00 + 32'(i));
            total++;
            if (rd_data[i] !== exp_d) begin bad++; $display("FAIL midburst_data[%0d]: got %h want %h", i, rd_data[i], exp_d); end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_write_read();
        test_strobe_backpressure();
        test_simultaneous();
        test_range();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1);
    end
endmodule
